// File: rtl/dcache_dm_wb_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
package dcache_dm_wb_pkg;
   localparam int BIT_W      = 32;
   localparam int LINE_W     = 128;
   localparam int OFFSET_W   = 2;
   localparam int ADDR_W     = 30;
   localparam int MEM_ADDR_W = 28;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WB    = 2'd1,
      S_ALLOC = 2'd2
   } state_t;

   // Tag width left after index and word offset are taken from the word address
   function automatic int tag_w(input int num_sets);
      return ADDR_W - OFFSET_W - $clog2(num_sets);
   endfunction
endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: one combinational read port by index and one
// write port (full-line refill or single-word update).
module dcache_line_array
   import dcache_dm_wb_pkg::*;
#(
   parameter int NUM_SETS = 8,
   parameter int IDX_W    = $clog2(NUM_SETS),
   parameter int TAG_W    = tag_w(NUM_SETS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_W-1:0]    idx,
   output logic                rd_valid,
   output logic                rd_dirty,
   output logic [TAG_W-1:0]    rd_tag,
   output logic [LINE_W-1:0]   rd_data,
   input  logic                fill_en,
   input  logic [TAG_W-1:0]    fill_tag,
   input  logic [LINE_W-1:0]   fill_data,
   input  logic                word_en,
   input  logic [OFFSET_W-1:0] word_off,
   input  logic [BIT_W-1:0]    word_data
);
   logic [LINE_W-1:0] data_q [NUM_SETS];
   logic [TAG_W-1:0]  tag_q  [NUM_SETS];
   logic [NUM_SETS-1:0] valid_q, dirty_q;

   assign rd_valid = valid_q[idx];
   assign rd_dirty = dirty_q[idx];
   assign rd_tag   = tag_q[idx];
   assign rd_data  = data_q[idx];

   // Status bits: cleared by reset, refill makes a line valid+clean, word write dirties it
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_en) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (word_en) begin
         dirty_q[idx] <= 1'b1;
      end
   end

   // Payload arrays are never reset; valid bits guard their contents
   always_ff @(posedge clk) begin
      if (fill_en) begin
         data_q[idx] <= fill_data;
         tag_q[idx]  <= fill_tag;
      end else if (word_en) begin
         data_q[idx][word_off*BIT_W +: BIT_W] <= word_data;
      end
   end
endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// and a 128-bit block memory. Hit logic and miss FSM live here.
module dcache_dm_wb
   import dcache_dm_wb_pkg::*;
#(
   parameter int BIT_W_P  = 32,
   parameter int NUM_SETS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  proc_read,
   input  logic                  proc_write,
   input  logic [ADDR_W-1:0]     proc_addr,
   input  logic [BIT_W_P-1:0]    proc_wdata,
   output logic [BIT_W_P-1:0]    proc_rdata,
   output logic                  proc_stall,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0]     mem_wdata,
   input  logic [LINE_W-1:0]     mem_rdata,
   input  logic                  mem_ready
);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = tag_w(NUM_SETS);

   state_t state, state_n;

   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    tag;
   logic [OFFSET_W-1:0] off;
   logic                rd_valid, rd_dirty, hit, req, fill_en, word_en;
   logic [TAG_W-1:0]    rd_tag;
   logic [LINE_W-1:0]   rd_data;

   assign off = proc_addr[OFFSET_W-1:0];
   assign idx = proc_addr[OFFSET_W +: IDX_W];
   assign tag = proc_addr[ADDR_W-1 -: TAG_W];
   assign req = proc_read | proc_write;
   assign hit = rd_valid & (rd_tag == tag);

   // Refill on the ALLOC completion; word write only on an IDLE hit (a replayed
   // write therefore merges into the freshly filled line)
   assign fill_en = ~rst & (state == S_ALLOC) & mem_ready;
   assign word_en = ~rst & (state == S_IDLE) & proc_write & hit;

   dcache_line_array #(.NUM_SETS(NUM_SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_lines (
      .clk       (clk),
      .rst       (rst),
      .idx       (idx),
      .rd_valid  (rd_valid),
      .rd_dirty  (rd_dirty),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .fill_en   (fill_en),
      .fill_tag  (tag),
      .fill_data (mem_rdata),
      .word_en   (word_en),
      .word_off  (off),
      .word_data (proc_wdata)
   );

   // Read data is the pre-write word even when read and write coincide
   assign proc_rdata = rd_data[off*BIT_W_P +: BIT_W_P];
   // Victim line is stable through WB: proc inputs are held and the array is untouched
   assign mem_wdata  = rd_data;

   // State register; reset abandons any in-flight memory transaction
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Next state and outputs; memory strobes decode from the state register only
   always_comb begin
      state_n    = state;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      proc_stall = 1'b0;
      case (state)
         S_IDLE: begin
            proc_stall = req & ~hit;
            if (req && !hit) state_n = rd_dirty ? S_WB : S_ALLOC;
         end
         S_WB: begin
            proc_stall = 1'b1;
            mem_write  = 1'b1;
            mem_addr   = {rd_tag, idx};
            if (mem_ready) state_n = S_ALLOC;
         end
         S_ALLOC: begin
            proc_stall = 1'b1;
            mem_read   = 1'b1;
            mem_addr   = {tag, idx};
            if (mem_ready) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
      if (rst) proc_stall = 1'b0;
   end
endmodule
